// File: rtl/snake_pkg.sv
// Shared snake definitions: direction and FSM state enums, plus the step
// size and playfield bounds used by the controller, food and drawing blocks.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  localparam int SNAKE_STEP    = 10;
  localparam int SNAKE_START_X = 320;
  localparam int SNAKE_START_Y = 240;
  localparam int SNAKE_X_MIN   = 0;
  localparam int SNAKE_X_MAX   = 630;
  localparam int SNAKE_Y_MIN   = 0;
  localparam int SNAKE_Y_MAX   = 470;

  // UP/DOWN and LEFT/RIGHT share bit 1 and differ only in bit 0.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a ^ b) == 2'b01;
  endfunction

endpackage

// File: rtl/snake_step_div.sv
// Step divider: counts frames while enabled and flags the cycle in which
// the count wraps; the count is held at zero whenever disabled.
module snake_step_div #(
  parameter int STEP_FRAMES = 6
) (
  input  logic frame_clk,
  input  logic Reset_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_FRAMES - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = en && (cnt_reg == LAST);

  // Frame counter, cleared outside the enabled state so every run starts fresh.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_reg <= '0;
    end else if (!en || cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/snake_ctrl.sv
// Snake controller: game FSM, direction filtering, body shift register,
// growth, and wall/self collision. Define SNAKE_WRAP_EN to make the head
// wrap to the opposite wall instead of ending the game.
module snake_ctrl
  import snake_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int STEP        = SNAKE_STEP,
  parameter int STEP_FRAMES = 6,
  parameter int START_X     = SNAKE_START_X,
  parameter int START_Y     = SNAKE_START_Y,
  parameter int X_MIN       = SNAKE_X_MIN,
  parameter int X_MAX       = SNAKE_X_MAX,
  parameter int Y_MIN       = SNAKE_Y_MIN,
  parameter int Y_MAX       = SNAKE_Y_MAX
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       start,
  input  logic [1:0] dir_in,
  input  logic       dir_valid,
  input  logic [9:0] fruitX,
  input  logic [9:0] fruitY,
  output logic [9:0] headX,
  output logic [9:0] headY,
  output logic [4:0] length,
  output logic       eat,
  output logic       game_over,
  input  logic [3:0] seg_idx,
  output logic [9:0] seg_x,
  output logic [9:0] seg_y
);

  localparam logic signed [10:0] STEP_S    = 11'(STEP);
  localparam logic signed [10:0] XMIN_S    = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S    = 11'(X_MAX);
  localparam logic signed [10:0] YMIN_S    = 11'(Y_MIN);
  localparam logic signed [10:0] YMAX_S    = 11'(Y_MAX);
  localparam logic [4:0]         MAX_LEN_L = 5'(MAX_LEN);
  localparam logic [9:0]         START_X_L = 10'(START_X);
  localparam logic [9:0]         START_Y_L = 10'(START_Y);

  state_t     state_reg;
  dir_t       dir_reg;
  dir_t       pend_reg;
  logic [9:0] seg_x_reg [MAX_LEN];
  logic [9:0] seg_y_reg [MAX_LEN];
  logic [4:0] len_reg;
  logic       eat_reg;
  logic       go_reg;

  logic              run;
  logic              tick;
  logic              req_ok;
  dir_t              step_dir;
  logic signed [10:0] hx_s, hy_s;
  logic signed [10:0] nx_raw, ny_raw;
  logic              x_lo, x_hi, y_lo, y_hi;
  logic [9:0]        nx, ny;
  logic              wall;
  logic              grow;
  logic [MAX_LEN-1:0] hit;
  logic              collide;
  logic              shift;
  logic              reinit;

  assign run = (state_reg == RUN);

  snake_step_div #(
    .STEP_FRAMES(STEP_FRAMES)
  ) u_step_div (
    .frame_clk(frame_clk),
    .Reset_n  (Reset_n),
    .en       (run),
    .tick     (tick)
  );

  // A same-cycle legal request counts for the step, so a late turn is never
  // checked against a stale direction.
  assign req_ok   = run && dir_valid && !is_reverse(dir_t'(dir_in), dir_reg);
  assign step_dir = req_ok ? dir_t'(dir_in) : pend_reg;

  // Candidate head position in signed 11-bit so moving below zero goes negative.
  always_comb begin
    hx_s   = $signed({1'b0, seg_x_reg[0]});
    hy_s   = $signed({1'b0, seg_y_reg[0]});
    nx_raw = hx_s;
    ny_raw = hy_s;
    case (step_dir)
      UP:      ny_raw = hy_s - STEP_S;
      DOWN:    ny_raw = hy_s + STEP_S;
      LEFT:    nx_raw = hx_s - STEP_S;
      default: nx_raw = hx_s + STEP_S;
    endcase
  end

  assign x_lo = (nx_raw < XMIN_S);
  assign x_hi = (nx_raw > XMAX_S);
  assign y_lo = (ny_raw < YMIN_S);
  assign y_hi = (ny_raw > YMAX_S);

`ifdef SNAKE_WRAP_EN
  localparam logic [9:0] XMIN_U = 10'(X_MIN);
  localparam logic [9:0] XMAX_U = 10'(X_MAX);
  localparam logic [9:0] YMIN_U = 10'(Y_MIN);
  localparam logic [9:0] YMAX_U = 10'(Y_MAX);

  // Crossing a wall re-enters from the opposite bound and is never fatal.
  always_comb begin
    nx   = x_lo ? XMAX_U : (x_hi ? XMIN_U : nx_raw[9:0]);
    ny   = y_lo ? YMAX_U : (y_hi ? YMIN_U : ny_raw[9:0]);
    wall = 1'b0;
  end
`else
  // Leaving the playfield is a collision; the head coordinates are then unused.
  always_comb begin
    nx   = nx_raw[9:0];
    ny   = ny_raw[9:0];
    wall = x_lo | x_hi | y_lo | y_hi;
  end
`endif

  assign grow = (nx == fruitX) && (ny == fruitY);

  // The last live segment vacates its cell on a plain move, so it only
  // counts as an obstacle when the snake grows.
  assign hit[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < MAX_LEN; gi++) begin : g_hit
      assign hit[gi] = (seg_x_reg[gi] == nx) && (seg_y_reg[gi] == ny) &&
                       (grow ? (5'(gi) < len_reg) : (5'(gi + 1) < len_reg));
    end
  endgenerate

  assign collide = wall || (|hit);
  assign shift   = run && tick && !collide;
  assign reinit  = (state_reg == GAME_OVER) && start;

  // Game FSM with direction, length, eat pulse and game-over flag.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      dir_reg   <= RIGHT;
      pend_reg  <= RIGHT;
      len_reg   <= 5'd1;
      eat_reg   <= 1'b0;
      go_reg    <= 1'b0;
    end else begin
      eat_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) state_reg <= RUN;
        end
        RUN: begin
          if (req_ok) pend_reg <= dir_t'(dir_in);
          if (tick) begin
            if (collide) begin
              state_reg <= GAME_OVER;
              go_reg    <= 1'b1;
            end else begin
              dir_reg  <= step_dir;
              pend_reg <= step_dir;
              eat_reg  <= grow;
              if (grow && len_reg < MAX_LEN_L) len_reg <= len_reg + 5'd1;
            end
          end
        end
        GAME_OVER: begin
          if (start) begin
            state_reg <= IDLE;
            go_reg    <= 1'b0;
            dir_reg   <= RIGHT;
            pend_reg  <= RIGHT;
            len_reg   <= 5'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Body shift register: head takes the new position, each segment follows.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      seg_x_reg[0] <= START_X_L;
      seg_y_reg[0] <= START_Y_L;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_reg[i] <= '0;
        seg_y_reg[i] <= '0;
      end
    end else if (reinit) begin
      seg_x_reg[0] <= START_X_L;
      seg_y_reg[0] <= START_Y_L;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_reg[i] <= '0;
        seg_y_reg[i] <= '0;
      end
    end else if (shift) begin
      seg_x_reg[0] <= nx;
      seg_y_reg[0] <= ny;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_reg[i] <= seg_x_reg[i-1];
        seg_y_reg[i] <= seg_y_reg[i-1];
      end
    end
  end

  // Drawing read port: segments beyond the live length read as zero.
  always_comb begin
    seg_x = '0;
    seg_y = '0;
    if ({1'b0, seg_idx} < len_reg) begin
      seg_x = seg_x_reg[seg_idx];
      seg_y = seg_y_reg[seg_idx];
    end
  end

  assign headX     = seg_x_reg[0];
  assign headY     = seg_y_reg[0];
  assign length    = len_reg;
  assign eat       = eat_reg;
  assign game_over = go_reg;

endmodule

// File: doc/snake_ctrl.md
SNAKE_CTRL -- requirements
Module: snake_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): MAX_LEN, 16, maximum body segments.
REQ-002 STEP, 10, pixels moved per step, equal to the food size.
REQ-003 STEP_FRAMES, 6, frame_clk cycles per step.
REQ-004 START_X, 320, reset head X; START_Y, 240, reset head Y.
REQ-005 X_MIN, 0; X_MAX, 630; Y_MIN, 0; Y_MAX, 470: legal head bounds, inclusive.
REQ-006 frame_clk  in  1  sole clock; all state SHALL be on its rising edge.
REQ-007 Reset_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  level; leaves IDLE or GAME_OVER.
REQ-009 dir_in  in  2  requested direction: 0=UP, 1=DOWN, 2=LEFT, 3=RIGHT.
REQ-010 dir_valid  in  1  qualifies dir_in for one cycle.
REQ-011 fruitX, fruitY  in  10 each  current fruit position from the food block.
REQ-012 headX, headY  out  10 each  registered head position, fed to the food block.
REQ-013 length  out  5  current segment count.
REQ-014 eat  out  1  one-cycle pulse on a step that lands on the fruit.
REQ-015 game_over  out  1  high while in GAME_OVER.
REQ-016 seg_idx  in  4; seg_x, seg_y  out  10 each  combinational read of segment seg_idx, for drawing.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and GAME_OVER. IDLE->RUN on start; RUN->GAME_OVER on collision; GAME_OVER->IDLE on start, re-initialising as at reset.
REQ-018 A step counter SHALL count 0..STEP_FRAMES-1 only in RUN; the step tick is the cycle the counter wraps.
REQ-019 A dir_valid request SHALL be latched as pending unless it is the exact reverse of the current direction; a reverse request SHALL be ignored. The last legal request before a tick wins.
REQ-020 On a tick, the current direction SHALL become the pending direction. next head = head ± STEP on the axis of that direction.
REQ-021 Wall collision: next head outside [X_MIN,X_MAX] x [Y_MIN,Y_MAX]. Arithmetic SHALL be 11-bit so that an underflow below 0 is detected.
REQ-022 grow = (next head == fruit).
REQ-023 Self collision: next head equals seg[i] for i in 1..length-2 when not growing, or 1..length-1 when growing.
REQ-024 On a collision the tick SHALL NOT update segments, length or eat; the FSM enters GAME_OVER on the next edge.
REQ-025 Otherwise the body SHALL shift: seg[0] = next head, seg[i] = old seg[i-1].
REQ-026 When grow is true, eat SHALL pulse that cycle and length SHALL increment, saturating at MAX_LEN. At saturation the snake moves without growing, but eat still pulses.
REQ-027 headX/headY SHALL equal seg[0]. For seg_idx >= length, seg_x/seg_y SHALL read 0.
REQ-028 A start held in RUN SHALL have no effect. dir_valid SHALL be ignored outside RUN.

Reset
REQ-029 While Reset_n is low: state=IDLE, seg[0]=(START_X,START_Y), other segments 0, length=1, direction=RIGHT, pending=RIGHT, counter=0, eat=0, game_over=0.
REQ-030 Reset asserted mid-step SHALL abandon the step; no partial shift SHALL be visible.

Configuration
REQ-031 Macro SNAKE_WRAP_EN: when defined, a wall crossing SHALL wrap to the opposite bound (X_MAX+STEP->X_MIN, X_MIN-STEP->X_MAX, Y likewise) and SHALL NOT cause a collision. Without it, REQ-021 applies.

Structure
REQ-032 Package snake_pkg SHALL hold the dir_t enum, the state_t enum, and the STEP and bound constants shared with the food and drawing blocks.
REQ-033 The step counter SHALL be a sub-module, snake_step_div (parameter STEP_FRAMES; outputs tick).

Verification
REQ-034 Reset, start, no dir_valid: after 6 cycles headX=330, headY=240, length=1, eat=0.
REQ-035 Running RIGHT, request LEFT (reverse) then UP in the same step window: the next step gives headY=230, headX unchanged.
REQ-036 fruit=(340,240), head=(320,240) RIGHT: eat pulses exactly once at head=340 and length becomes 2; the tail follows on the next step.
REQ-037 Head (630,240) RIGHT: without macro, game_over=1 and head stays 630; with SNAKE_WRAP_EN, head=0 and play continues.
REQ-038 length=5 with a U-turn into the body: game_over asserts and segments are frozen. Then start -> IDLE, length=1, head=(320,240).
REQ-039 Reset_n pulsed low on a tick cycle: all outputs take the REQ-029 values immediately, asynchronously.
